aes_spi_master: RTL

- Serial host controller that feeds the AES encryption and decryption slaves over their shared mosi/miso link.
- Accepts a 128-bit key and a 128-bit text block through a valid/ready handshake.
- Selects the target slave, shifts the key then the text out MSB-first, waits a fixed compute window, then shifts the 128-bit result back in.
- Presents the result in parallel with a one-cycle valid pulse; replaces ad-hoc top-level sequencing.

---
 rtl/aes_spi_pkg.sv | 19 +
 rtl/aes_spi_master_if.sv | 44 ++++
 rtl/aes_spi_shifter.sv | 43 ++++
 rtl/aes_spi_master.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/aes_spi_pkg.sv
// Shared types and constants for the AES serial host controller.
package aes_spi_pkg;

    localparam int unsigned DEFAULT_DATA_W      = 128;
    localparam int unsigned DEFAULT_WAIT_CYCLES = 56;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StSendKey,
        StSendText,
        StWait,
        StRecv,
        StDone
    } state_e;

endpackage

// File: rtl/aes_spi_master_if.sv
// Host request/result handshake plus the serial slave link of aes_spi_master.
// Optional AES_SPI_CHECK_EN adds the expected-result compare signals.
interface aes_spi_master_if
    import aes_spi_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W
);
    logic              start_valid;
    logic              start_ready;
    logic              mode;
    logic [DATA_W-1:0] key_in;
    logic [DATA_W-1:0] text_in;
    logic              mosi;
    logic              miso;
    logic              cs_enc_n;
    logic              cs_dec_n;
    logic              busy;
    logic [DATA_W-1:0] result_out;
    logic              result_valid;
`ifdef AES_SPI_CHECK_EN
    logic [DATA_W-1:0] expect_in;
    logic              match;
    logic              match_valid;
`endif

    modport master (
        input  start_valid, mode, key_in, text_in, miso,
`ifdef AES_SPI_CHECK_EN
        input  expect_in,
        output match, match_valid,
`endif
        output start_ready, mosi, cs_enc_n, cs_dec_n, busy, result_out, result_valid
    );

    modport slave (
        output start_valid, mode, key_in, text_in, miso,
`ifdef AES_SPI_CHECK_EN
        output expect_in,
        input  match, match_valid,
`endif
        input  start_ready, mosi, cs_enc_n, cs_dec_n, busy, result_out, result_valid
    );

endinterface

// File: rtl/aes_spi_shifter.sv
// Parallel-load shift register: serial out from the MSB, serial in at the LSB.
// shifted_o is the value the register takes on a shift, so callers can capture
// a completed word on the same edge as its last bit arrives.
module aes_spi_shifter
    import aes_spi_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic              shift_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              ser_i,
    output logic              ser_o,
    output logic [DATA_W-1:0] shifted_o
);

    logic [DATA_W-1:0] sh_q, sh_d;

    assign shifted_o = {sh_q[DATA_W-2:0], ser_i};
    assign ser_o     = sh_q[DATA_W-1];

    // Next value: load wins over shift.
    always_comb begin
        sh_d = sh_q;
        if (load_i) begin
            sh_d = data_i;
        end else if (shift_i) begin
            sh_d = shifted_o;
        end
    end

    // Register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sh_q <= '0;
        end else begin
            sh_q <= sh_d;
        end
    end

endmodule

// File: rtl/aes_spi_master.sv
// Serial host controller for the AES encrypt/decrypt slaves: sends key then
// text MSB-first, waits the slave compute window, then receives the result.
// Optional build macro AES_SPI_CHECK_EN adds an expected-result comparator.
module aes_spi_master
    import aes_spi_pkg::*;
#(
    parameter int unsigned DATA_W      = DEFAULT_DATA_W,
    parameter int unsigned WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
    input logic              clk,
    input logic              reset,
    aes_spi_master_if.master bus
);

    localparam logic [7:0] LastBit  = 8'(DATA_W - 1);
    localparam logic [7:0] LastWait = 8'(WAIT_CYCLES - 1);

    state_e            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] text_q, text_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              result_valid_q, result_valid_d;
    logic              cs_enc_n_q, cs_enc_n_d;
    logic              cs_dec_n_q, cs_dec_n_d;

    logic              sh_load, sh_shift, sh_ser_in, sh_ser_out;
    logic [DATA_W-1:0] sh_data_in, sh_shifted;

`ifdef AES_SPI_CHECK_EN
    logic [DATA_W-1:0] expect_q, expect_d;
    logic              match_q, match_d;
    logic              match_valid_q, match_valid_d;
`endif

    // The shifter MSB is a flop, so it drives mosi directly; it is zero once
    // the text has been shifted out, which keeps mosi low through WAIT/RECV.
    aes_spi_shifter #(
        .DATA_W (DATA_W)
    ) u_shifter (
        .clk       (clk),
        .reset     (reset),
        .load_i    (sh_load),
        .shift_i   (sh_shift),
        .data_i    (sh_data_in),
        .ser_i     (sh_ser_in),
        .ser_o     (sh_ser_out),
        .shifted_o (sh_shifted)
    );

    // Next-state, counter and datapath control.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q + 8'd1;
        text_d         = text_q;
        result_d       = result_q;
        result_valid_d = 1'b0;
        cs_enc_n_d     = cs_enc_n_q;
        cs_dec_n_d     = cs_dec_n_q;
        sh_load        = 1'b0;
        sh_shift       = 1'b0;
        sh_ser_in      = 1'b0;
        sh_data_in     = text_q;
`ifdef AES_SPI_CHECK_EN
        expect_d       = expect_q;
        match_d        = match_q;
        match_valid_d  = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                cnt_d      = 8'd0;
                sh_data_in = bus.key_in;
                if (bus.start_valid) begin
                    sh_load    = 1'b1;
                    text_d     = bus.text_in;
                    cs_enc_n_d = (bus.mode != MODE_ENC);
                    cs_dec_n_d = (bus.mode != MODE_DEC);
`ifdef AES_SPI_CHECK_EN
                    expect_d   = bus.expect_in;
`endif
                    state_d    = StSendKey;
                end
            end
            StSendKey: begin
                if (cnt_q == LastBit) begin
                    // Reload with the text so its MSB follows the key LSB.
                    sh_load = 1'b1;
                    cnt_d   = 8'd0;
                    state_d = StSendText;
                end else begin
                    sh_shift = 1'b1;
                end
            end
            StSendText: begin
                sh_shift = 1'b1;
                if (cnt_q == LastBit) begin
                    cnt_d   = 8'd0;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (cnt_q == LastWait) begin
                    cnt_d   = 8'd0;
                    state_d = StRecv;
                end
            end
            StRecv: begin
                sh_shift  = 1'b1;
                sh_ser_in = bus.miso;
                if (cnt_q == LastBit) begin
                    cnt_d          = 8'd0;
                    result_d       = sh_shifted;
                    result_valid_d = 1'b1;
                    cs_enc_n_d     = 1'b1;
                    cs_dec_n_d     = 1'b1;
`ifdef AES_SPI_CHECK_EN
                    match_d        = (sh_shifted == expect_q);
                    match_valid_d  = 1'b1;
`endif
                    state_d        = StDone;
                end
            end
            StDone: begin
                cnt_d   = 8'd0;
                state_d = StIdle;
            end
            default: begin
                cnt_d   = 8'd0;
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StIdle;
            cnt_q          <= 8'd0;
            text_q         <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            cs_enc_n_q     <= 1'b1;
            cs_dec_n_q     <= 1'b1;
`ifdef AES_SPI_CHECK_EN
            expect_q       <= '0;
            match_q        <= 1'b0;
            match_valid_q  <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            text_q         <= text_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            cs_enc_n_q     <= cs_enc_n_d;
            cs_dec_n_q     <= cs_dec_n_d;
`ifdef AES_SPI_CHECK_EN
            expect_q       <= expect_d;
            match_q        <= match_d;
            match_valid_q  <= match_valid_d;
`endif
        end
    end

    assign bus.start_ready  = (state_q == StIdle);
    assign bus.busy         = (state_q != StIdle);
    assign bus.mosi         = sh_ser_out;
    assign bus.cs_enc_n     = cs_enc_n_q;
    assign bus.cs_dec_n     = cs_dec_n_q;
    assign bus.result_out   = result_q;
    assign bus.result_valid = result_valid_q;
`ifdef AES_SPI_CHECK_EN
    assign bus.match        = match_q;
    assign bus.match_valid  = match_valid_q;
`endif

endmodule
